sram_test_status: RTL and testbench

- Downstream consumer of the SRAM tester's status outputs (test_done, test_pass, pattern_state, prev_read/expected data).
- Counts completed full-memory passes.
- Captures a snapshot of the first failure.
- Drives a board LED bank: a live progress view while running, and a paged dump of the captured failure words after a failure.

---
 rtl/sram_test_status_pkg.sv | 15 +
 rtl/sram_test_status_defs.v | 8 +
 rtl/sram_test_status_led_pager.sv | 37 +++
 rtl/sram_test_status.sv | 183 ++++++++++++++++++
 tb/tb_sram_test_status.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_test_status_pkg.sv
// Types and helpers shared by sram_test_status and its LED pager.
package sram_test_status_pkg;
  `include "sram_test_status_defs.v"

  typedef enum logic [1:0] {
    ST_RUN     = STATUS_RUN,
    ST_FAILED  = STATUS_FAILED,
    ST_TIMEOUT = STATUS_TIMEOUT
  } status_state_e;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_test_status_defs.v
// Shared status-state encodings and the TIMEOUT LED pattern for sram_test_status.
`ifndef SRAM_TEST_STATUS_DEFS_V
`define SRAM_TEST_STATUS_DEFS_V
localparam logic [1:0] STATUS_RUN     = 2'b00;
localparam logic [1:0] STATUS_FAILED  = 2'b01;
localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
localparam logic [7:0] TIMEOUT_LED    = 8'hA5;
`endif

// File: rtl/sram_test_status_led_pager.sv
// Steps a page index every PAGE_CYCLES clocks while enabled; held at page 0 otherwise.
module led_pager
  import sram_test_status_pkg::*;
#(
  parameter int PAGES       = 4,
  parameter int PAGE_CYCLES = 50000000,
  parameter int PAGE_W      = clog2_min1(PAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [PAGE_W-1:0] page,
  output logic              page_tick
);

  localparam int DWELL_W = clog2_min1(PAGE_CYCLES);

  logic [DWELL_W-1:0] dwell;

  assign page_tick = enable && (dwell == DWELL_W'(PAGE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell <= '0;
      page  <= '0;
    end else if (!enable) begin
      dwell <= '0;
      page  <= '0;
    end else if (page_tick) begin
      dwell <= '0;
      page  <= (page == PAGE_W'(PAGES - 1)) ? '0 : page + 1'b1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/sram_test_status.sv
// Pass counter, first-failure snapshot and LED status view for the SRAM tester.
// Optional watchdog enabled by defining SRAM_TEST_STATUS_TIMEOUT_EN.
module sram_test_status
  import sram_test_status_pkg::*;
#(
  parameter int DATA_BITS        = 16,
  parameter int ITER_BITS        = 16,
  parameter int HEARTBEAT_CYCLES = 25000000,
  parameter int PAGE_CYCLES      = 50000000,
  parameter int TIMEOUT_CYCLES   = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 test_done,
  input  logic                 test_pass,
  input  logic [2:0]           pattern_state,
  input  logic [DATA_BITS-1:0] prev_read_data,
  input  logic [DATA_BITS-1:0] prev_expected_data,
  output logic [ITER_BITS-1:0] iter_count,
  output logic                 fail,
  output logic [DATA_BITS-1:0] fail_read_data,
  output logic [DATA_BITS-1:0] fail_expected_data,
  output logic [2:0]           fail_pattern_state,
  output logic [ITER_BITS-1:0] fail_iter,
  output logic [1:0]           status_state,
  output logic                 heartbeat,
  output logic [7:0]           led,
  output logic [1:0]           led_page
);

  localparam int NPAGES = 2 * (DATA_BITS / 8);
  localparam int PAGE_W = clog2_min1(NPAGES);
  localparam int HB_W   = clog2_min1(HEARTBEAT_CYCLES);

  status_state_e        state;
  logic [DATA_BITS-1:0] read_d;
  logic [DATA_BITS-1:0] expected_d;
  logic [2:0]           pattern_d;
  logic                 test_pass_d;
  logic                 fail_edge;
  logic                 wd_expire;
  logic [HB_W-1:0]      hb_cnt;
  logic [PAGE_W-1:0]    page;
  logic [PAGE_W-1:0]    byte_sel;
  logic                 unused_page_tick;
  logic [6:0]           iter_low;
  logic [2*DATA_BITS-1:0] dump;

  assign status_state = state;

  // Debug words have already advanced when test_pass falls; capture from the delayed copies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_d      <= '0;
      expected_d  <= '0;
      pattern_d   <= '0;
      test_pass_d <= 1'b0;
    end else begin
      read_d      <= prev_read_data;
      expected_d  <= prev_expected_data;
      pattern_d   <= pattern_state;
      test_pass_d <= test_pass;
    end
  end

  assign fail_edge = test_pass_d & ~test_pass;

`ifdef SRAM_TEST_STATUS_TIMEOUT_EN
  localparam int WD_W = clog2_min1(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != ST_RUN || test_done) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES - 1)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = (state == ST_RUN) && !test_done
                     && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign wd_expire      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_RUN;
      iter_count         <= '0;
      fail               <= 1'b0;
      fail_read_data     <= '0;
      fail_expected_data <= '0;
      fail_pattern_state <= '0;
      fail_iter          <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (fail_edge) begin
            state              <= ST_FAILED;
            fail               <= 1'b1;
            fail_read_data     <= read_d;
            fail_expected_data <= expected_d;
            fail_pattern_state <= pattern_d;
            fail_iter          <= iter_count;
          end else if (wd_expire) begin
            state <= ST_TIMEOUT;
            fail  <= 1'b1;
          end else if (test_done && !(&iter_count)) begin
            iter_count <= iter_count + 1'b1;
          end
        end
        ST_FAILED, ST_TIMEOUT: begin
          state <= state;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (state != ST_RUN) begin
      heartbeat <= 1'b1;
    end else if (hb_cnt == '0) begin
      hb_cnt    <= HB_W'(HEARTBEAT_CYCLES - 1);
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt - 1'b1;
    end
  end

  led_pager #(
    .PAGES       (NPAGES),
    .PAGE_CYCLES (PAGE_CYCLES),
    .PAGE_W      (PAGE_W)
  ) u_led_pager (
    .clk       (clk),
    .reset     (reset),
    .enable    (state == ST_FAILED),
    .page      (page),
    .page_tick (unused_page_tick)
  );

  generate
    if (ITER_BITS >= 7) begin : g_iter_wide
      assign iter_low = iter_count[6:0];
    end else begin : g_iter_narrow
      assign iter_low = {{(7 - ITER_BITS){1'b0}}, iter_count};
    end
  endgenerate

  // Page 0 is the most significant read byte; expected bytes follow the read bytes.
  assign dump     = {fail_read_data, fail_expected_data};
  assign byte_sel = PAGE_W'(NPAGES - 1) - page;

  always_comb begin
    led      = {heartbeat, iter_low};
    led_page = 2'b00;
    case (state)
      ST_FAILED: begin
        led      = dump[{byte_sel, 3'b000} +: 8];
        led_page = 2'(page);
      end
      ST_TIMEOUT: begin
        led = TIMEOUT_LED;
      end
      default: begin
        led      = {heartbeat, iter_low};
        led_page = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_test_status.sv
// Directed bench for sram_test_status with short heartbeat/page/timeout periods.
module tb_sram_test_status;

  logic        clk;
  logic        reset;
  logic        test_done;
  logic        test_pass;
  logic [2:0]  pattern_state;
  logic [15:0] prev_read_data;
  logic [15:0] prev_expected_data;
  logic [3:0]  iter_count;
  logic        fail;
  logic [15:0] fail_read_data;
  logic [15:0] fail_expected_data;
  logic [2:0]  fail_pattern_state;
  logic [3:0]  fail_iter;
  logic [1:0]  status_state;
  logic        heartbeat;
  logic [7:0]  led;
  logic [1:0]  led_page;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  sram_test_status #(
    .DATA_BITS        (16),
    .ITER_BITS        (4),
    .HEARTBEAT_CYCLES (4),
    .PAGE_CYCLES      (3),
    .TIMEOUT_CYCLES   (10)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .test_done          (test_done),
    .test_pass          (test_pass),
    .pattern_state      (pattern_state),
    .prev_read_data     (prev_read_data),
    .prev_expected_data (prev_expected_data),
    .iter_count         (iter_count),
    .fail               (fail),
    .fail_read_data     (fail_read_data),
    .fail_expected_data (fail_expected_data),
    .fail_pattern_state (fail_pattern_state),
    .fail_iter          (fail_iter),
    .status_state       (status_state),
    .heartbeat          (heartbeat),
    .led                (led),
    .led_page           (led_page)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    assert (got === exp_v) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_iter"}, 32'(iter_count), 32'h0);
    chk({tag, "_fail"}, 32'(fail), 32'h0);
    chk({tag, "_state"}, 32'(status_state), 32'h0);
    chk({tag, "_led"}, 32'(led), 32'h0);
    chk({tag, "_led_page"}, 32'(led_page), 32'h0);
    chk({tag, "_hb"}, 32'(heartbeat), 32'h0);
    chk({tag, "_fail_read"}, 32'(fail_read_data), 32'h0);
    chk({tag, "_fail_exp"}, 32'(fail_expected_data), 32'h0);
    chk({tag, "_fail_pat"}, 32'(fail_pattern_state), 32'h0);
    chk({tag, "_fail_iter"}, 32'(fail_iter), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    test_done = 1'b0;
    test_pass = 1'b1;
    pattern_state = 3'd0;
    prev_read_data = 16'h0;
    prev_expected_data = 16'h0;
    tick(2);
    chk_reset_zero("por");
    reset = 1'b0;

    // Heartbeat: first edge after reset toggles, then every 4 cycles
    tick(1);
    chk("hb_p1", 32'(heartbeat), 32'h1);
    tick(3);
    chk("hb_p4", 32'(heartbeat), 32'h1);
    tick(1);
    chk("hb_p5", 32'(heartbeat), 32'h0);
    tick(3);
    chk("hb_p8", 32'(heartbeat), 32'h0);
    tick(1);
    chk("hb_p9", 32'(heartbeat), 32'h1);

    // Five isolated test_done pulses
    for (int i = 0; i < 5; i++) begin
      test_done = 1'b1;
      tick(1);
      test_done = 1'b0;
      chk("iter_step", 32'(iter_count), 32'(i + 1));
      tick(1);
    end
    chk("iter_5", 32'(iter_count), 32'd5);
    chk("led_low_5", 32'(led[6:0]), 32'd5);
    chk("fail_run", 32'(fail), 32'h0);
    chk("state_run", 32'(status_state), 32'h0);

    // Saturation: 20 back-to-back pulses from 5
    test_done = 1'b1;
    tick(9);
    chk("iter_14", 32'(iter_count), 32'hE);
    tick(11);
    test_done = 1'b0;
    chk("iter_sat", 32'(iter_count), 32'hF);
    tick(2);
    chk("iter_sat_hold", 32'(iter_count), 32'hF);

    // Failure capture uses the words from the cycle before test_pass falls
    prev_read_data = 16'h1234;
    prev_expected_data = 16'h1235;
    pattern_state = 3'd3;
    tick(1);
    test_pass = 1'b0;
    prev_read_data = 16'hABCD;
    prev_expected_data = 16'h0000;
    pattern_state = 3'd5;
    chk("fail_before_edge", 32'(fail), 32'h0);
    tick(1);
    prev_read_data = 16'h7777;
    prev_expected_data = 16'h8888;
    pattern_state = 3'd1;
    chk("fail_set", 32'(fail), 32'h1);
    chk("state_failed", 32'(status_state), 32'h1);
    chk("cap_read", 32'(fail_read_data), 32'h1234);
    chk("cap_exp", 32'(fail_expected_data), 32'h1235);
    chk("cap_pat", 32'(fail_pattern_state), 32'h3);
    chk("cap_iter", 32'(fail_iter), 32'hF);

    // Paged dump: read MSB, read LSB, expected MSB, expected LSB, wrap
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h12);
    for (int p = 0; p < 5; p++) begin
      logic [7:0] exp_led;
      exp_led = exp_q.pop_front();
      chk("page_led", 32'(led), 32'(exp_led));
      chk("page_idx", 32'(led_page), 32'(p % 4));
      chk("hb_failed", 32'(heartbeat), 32'h1);
      tick(3);
    end

    // FAILED is terminal: no recapture, no counting
    test_pass = 1'b1;
    tick(1);
    prev_read_data = 16'hFFFF;
    test_pass = 1'b0;
    test_done = 1'b1;
    tick(2);
    test_done = 1'b0;
    chk("no_recapture", 32'(fail_read_data), 32'h1234);
    chk("still_failed", 32'(status_state), 32'h1);
    chk("iter_frozen", 32'(iter_count), 32'hF);

    // Asynchronous reset mid-page
    @(posedge clk);
    #2;
    reset = 1'b1;
    test_pass = 1'b1;
    prev_read_data = 16'h0;
    #1;
    chk_reset_zero("async1");
    tick(1);
    reset = 1'b0;

    // test_done and failure in the same cycle: failure wins
    test_done = 1'b1;
    tick(1);
    test_done = 1'b0;
    tick(1);
    test_done = 1'b1;
    tick(1);
    test_done = 1'b0;
    chk("iter_2", 32'(iter_count), 32'd2);
    prev_read_data = 16'h5A5A;
    prev_expected_data = 16'hA5A5;
    pattern_state = 3'd6;
    tick(1);
    test_done = 1'b1;
    test_pass = 1'b0;
    prev_read_data = 16'h0;
    tick(1);
    test_done = 1'b0;
    chk("tie_state", 32'(status_state), 32'h1);
    chk("tie_iter", 32'(iter_count), 32'd2);
    chk("tie_fail_iter", 32'(fail_iter), 32'd2);
    chk("tie_cap_read", 32'(fail_read_data), 32'h5A5A);
    chk("tie_cap_exp", 32'(fail_expected_data), 32'hA5A5);
    chk("tie_cap_pat", 32'(fail_pattern_state), 32'd6);
    chk("tie_led", 32'(led), 32'h5A);
    test_done = 1'b1;
    tick(1);
    test_done = 1'b0;
    tick(1);
    chk("tie_iter_hold", 32'(iter_count), 32'd2);

    @(posedge clk);
    #3;
    reset = 1'b1;
    test_pass = 1'b1;
    #1;
    chk_reset_zero("async2");
    tick(1);
    reset = 1'b0;

    // Watchdog: 10 idle cycles expire it when enabled
    tick(9);
    chk("wd_pre", 32'(status_state), 32'h0);
    tick(1);
`ifdef SRAM_TEST_STATUS_TIMEOUT_EN
    chk("wd_state", 32'(status_state), 32'h2);
    chk("wd_led", 32'(led), 32'hA5);
    chk("wd_fail", 32'(fail), 32'h1);
    chk("wd_cap_none", 32'(fail_read_data), 32'h0);
    tick(1);
    chk("wd_hb", 32'(heartbeat), 32'h1);
`else
    chk("no_wd_state", 32'(status_state), 32'h0);
    chk("no_wd_fail", 32'(fail), 32'h0);
`endif

    @(posedge clk);
    #2;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      test_done = 1'b1;
      tick(1);
      test_done = 1'b0;
      tick(7);
    end
    chk("wd_kept_state", 32'(status_state), 32'h0);
    chk("wd_kept_fail", 32'(fail), 32'h0);
    chk("wd_kept_iter", 32'(iter_count), 32'd6);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
